// File: rtl/lsq_multi_cdb.sv
// In-order load/store queue: entries capture base/data off CDB_N result buses and issue only from the head.
// Latency: dispatch -> issue_valid 1 cycle; CDB/commit -> issue condition 1 cycle; issue is combinational from head state.
// Backpressure: disp_ready = !full (from registered count); issue payload held until issue_ready; retire waits for done.
module lsq_multi_cdb #(
  parameter int DEPTH  = 8,
  parameter int TAG_W  = 5,
  parameter int XLEN   = 32,
  parameter int CTRL_W = 8,
  parameter int CDB_N  = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      disp_valid,
  output logic                      disp_ready,
  input  logic                      disp_is_load,
  input  logic [TAG_W-1:0]          disp_tag,
  input  logic [CTRL_W-1:0]         disp_ctrl,
  input  logic                      disp_src1_ready,
  input  logic                      disp_src2_ready,
  input  logic [TAG_W-1:0]          disp_src1_tag,
  input  logic [TAG_W-1:0]          disp_src2_tag,
  input  logic [XLEN-1:0]           disp_src1_val,
  input  logic [XLEN-1:0]           disp_src2_val,
  input  logic [CDB_N-1:0]          cdb_valid,
  input  logic [CDB_N*TAG_W-1:0]    cdb_tag,
  input  logic [CDB_N*XLEN-1:0]     cdb_data,
  input  logic                      commit_valid,
  input  logic [TAG_W-1:0]          commit_tag,
  output logic                      issue_valid,
  input  logic                      issue_ready,
  output logic                      issue_is_load,
  output logic [TAG_W-1:0]          issue_tag,
  output logic [CTRL_W-1:0]         issue_ctrl,
  output logic [XLEN-1:0]           issue_base,
  output logic [XLEN-1:0]           issue_data,
  input  logic                      done,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      empty,
  output logic                      full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // One source operand: ready flag, producer tag and captured value.
  typedef struct packed {
    logic             rdy;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  val;
  } src_t;

  // One queue entry. src1 is the address base, src2 the store data.
  typedef struct packed {
    logic              valid;
    logic              is_load;
    logic              committed;
    logic              issued;
    logic [TAG_W-1:0]  tag;
    logic [CTRL_W-1:0] ctrl;
    src_t              s1;
    src_t              s2;
  } entry_t;

  entry_t           q [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;

  // Search the result buses for a tag; {hit, value}. Scanning from the top
  // down lets the lowest-indexed matching bus overwrite the others.
  function automatic logic [XLEN:0] cdb_lookup(input logic [TAG_W-1:0] t);
    logic [XLEN:0] r;
    r = '0;
    for (int b = CDB_N - 1; b >= 0; b--) begin
      if (cdb_valid[b] && (cdb_tag[b*TAG_W +: TAG_W] == t)) begin
        r = {1'b1, cdb_data[b*XLEN +: XLEN]};
      end
    end
    return r;
  endfunction

  entry_t        head_e;
  logic          disp_fire;
  logic          issue_fire;
  logic          retire;
  logic [XLEN:0] byp1;
  logic [XLEN:0] byp2;
  entry_t        new_e;

  logic [DEPTH-1:0] s1_hit;
  logic [DEPTH-1:0] s2_hit;
  logic [XLEN-1:0]  s1_cdb [DEPTH];
  logic [XLEN-1:0]  s2_cdb [DEPTH];

  assign head_e = q[head];

  // Occupancy flags come from the registered count, so a same-cycle retire
  // never opens a slot for a dispatch while full.
  assign full       = (count == CNT_W'(DEPTH));
  assign empty      = (count == '0);
  assign disp_ready = !full;

  assign disp_fire  = disp_valid && disp_ready;
  assign issue_fire = issue_valid && issue_ready;
  // done only retires an entry that has actually been handed to the LS unit.
  assign retire     = done && head_e.valid && head_e.issued;

  // Head eligibility: loads need the base; stores also need data and the ROB commit.
  assign issue_valid = head_e.valid && !head_e.issued && head_e.s1.rdy &&
                       (head_e.is_load || (head_e.s2.rdy && head_e.committed));

  assign issue_is_load = issue_valid & head_e.is_load;
  assign issue_tag     = issue_valid ? head_e.tag    : '0;
  assign issue_ctrl    = issue_valid ? head_e.ctrl   : '0;
  assign issue_base    = issue_valid ? head_e.s1.val : '0;
  assign issue_data    = issue_valid ? head_e.s2.val : '0;

  // Build the entry being dispatched, bypassing any same-cycle CDB result into a not-ready source.
  always_comb begin
    byp1 = cdb_lookup(disp_src1_tag);
    byp2 = cdb_lookup(disp_src2_tag);
    new_e           = '0;
    new_e.valid     = 1'b1;
    new_e.is_load   = disp_is_load;
    new_e.committed = 1'b0;
    new_e.issued    = 1'b0;
    new_e.tag       = disp_tag;
    new_e.ctrl      = disp_ctrl;
    new_e.s1.tag    = disp_src1_tag;
    new_e.s1.rdy    = disp_src1_ready | byp1[XLEN];
    new_e.s1.val    = disp_src1_ready ? disp_src1_val : byp1[XLEN-1:0];
    new_e.s2.tag    = disp_src2_tag;
    new_e.s2.rdy    = disp_src2_ready | byp2[XLEN];
    new_e.s2.val    = disp_src2_ready ? disp_src2_val : byp2[XLEN-1:0];
  end

  // Per-entry wakeup match for both sources against all buses.
  always_comb begin
    s1_hit = '0;
    s2_hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      {s1_hit[i], s1_cdb[i]} = cdb_lookup(q[i].s1.tag);
      {s2_hit[i], s2_cdb[i]} = cdb_lookup(q[i].s2.tag);
    end
  end

  // Queue state: flush/reset first, then wakeup, commit, issue mark, retire, dispatch.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (q[i].valid && !q[i].s1.rdy && s1_hit[i]) begin
          q[i].s1.rdy <= 1'b1;
          q[i].s1.val <= s1_cdb[i];
        end
        if (q[i].valid && !q[i].s2.rdy && s2_hit[i]) begin
          q[i].s2.rdy <= 1'b1;
          q[i].s2.val <= s2_cdb[i];
        end
        if (q[i].valid && !q[i].is_load && commit_valid && (q[i].tag == commit_tag)) begin
          q[i].committed <= 1'b1;
        end
      end

      if (issue_fire) begin
        q[head].issued <= 1'b1;
      end

      // Clearing issued as well keeps a stale flag from letting done retire an empty slot later.
      if (retire) begin
        q[head].valid  <= 1'b0;
        q[head].issued <= 1'b0;
        head           <= head + PTR_W'(1);
      end

      // tail never equals a live head while not full, so this write cannot clobber the head.
      if (disp_fire) begin
        q[tail] <= new_e;
        tail    <= tail + PTR_W'(1);
      end

      case ({disp_fire, retire})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_lsq_multi_cdb.sv
// Scoreboard bench for lsq_multi_cdb: directed scenarios followed by randomized traffic.
// Expected issue payloads are queued at dispatch and checked by an independent monitor.
// The reference model tracks queue contents as a list of instructions with known operand values.
`timescale 1ns/1ps
module tb_lsq_multi_cdb;
  localparam int DEPTH  = 8;
  localparam int TAG_W  = 5;
  localparam int XLEN   = 32;
  localparam int CTRL_W = 8;
  localparam int CDB_N  = 2;

  logic clk = 1'b0;
  logic reset = 1'b1, flush = 1'b0;
  logic disp_valid = 1'b0, disp_ready, disp_is_load = 1'b0;
  logic [TAG_W-1:0] disp_tag = '0, disp_src1_tag = '0, disp_src2_tag = '0;
  logic [CTRL_W-1:0] disp_ctrl = '0;
  logic disp_src1_ready = 1'b0, disp_src2_ready = 1'b0;
  logic [XLEN-1:0] disp_src1_val = '0, disp_src2_val = '0;
  logic [CDB_N-1:0] cdb_valid = '0;
  logic [CDB_N*TAG_W-1:0] cdb_tag = '0;
  logic [CDB_N*XLEN-1:0] cdb_data = '0;
  logic commit_valid = 1'b0;
  logic [TAG_W-1:0] commit_tag = '0;
  logic issue_valid, issue_ready = 1'b0, issue_is_load;
  logic [TAG_W-1:0] issue_tag;
  logic [CTRL_W-1:0] issue_ctrl;
  logic [XLEN-1:0] issue_base, issue_data;
  logic done = 1'b0;
  logic [$clog2(DEPTH):0] count;
  logic empty, full;

  always #5 clk = ~clk;

  lsq_multi_cdb #(.DEPTH(DEPTH), .TAG_W(TAG_W), .XLEN(XLEN), .CTRL_W(CTRL_W), .CDB_N(CDB_N)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_is_load(disp_is_load),
    .disp_tag(disp_tag), .disp_ctrl(disp_ctrl),
    .disp_src1_ready(disp_src1_ready), .disp_src2_ready(disp_src2_ready),
    .disp_src1_tag(disp_src1_tag), .disp_src2_tag(disp_src2_tag),
    .disp_src1_val(disp_src1_val), .disp_src2_val(disp_src2_val),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .commit_valid(commit_valid), .commit_tag(commit_tag),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_is_load(issue_is_load),
    .issue_tag(issue_tag), .issue_ctrl(issue_ctrl), .issue_base(issue_base), .issue_data(issue_data),
    .done(done), .count(count), .empty(empty), .full(full)
  );

  typedef struct {
    logic [TAG_W-1:0]  tag;
    logic              is_load;
    logic [CTRL_W-1:0] ctrl;
    logic [XLEN-1:0]   base;
    logic [XLEN-1:0]   data;
  } exp_t;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic             is_load;
    logic             committed;
  } ment_t;

  exp_t  exp_q[$];
  ment_t mq[$];
  exp_t  pend;
  int    occ = 0;
  bit    outstanding = 1'b0;
  bit    prev_xfer = 1'b0;
  int    checks = 0;
  int    errors = 0;
  logic [XLEN-1:0] val_of [16];
  logic [TAG_W-1:0] seq = '0;

  task automatic chk(string name, logic [95:0] act, logic [95:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic set_disp(bit ld, logic [TAG_W-1:0] tag, logic [CTRL_W-1:0] ctrl,
                          bit r1, logic [TAG_W-1:0] t1, logic [XLEN-1:0] v1,
                          bit r2, logic [TAG_W-1:0] t2, logic [XLEN-1:0] v2,
                          logic [XLEN-1:0] eb, logic [XLEN-1:0] ed);
    disp_valid = 1'b1; disp_is_load = ld; disp_tag = tag; disp_ctrl = ctrl;
    disp_src1_ready = r1; disp_src1_tag = t1; disp_src1_val = v1;
    disp_src2_ready = r2; disp_src2_tag = t2; disp_src2_val = v2;
    pend.tag = tag; pend.is_load = ld; pend.ctrl = ctrl; pend.base = eb; pend.data = ed;
  endtask

  task automatic idle();
    disp_valid = 1'b0; cdb_valid = '0; commit_valid = 1'b0; flush = 1'b0; done = 1'b0;
  endtask

  // Advance one clock and update the model with what the current inputs do at that edge.
  task automatic tick();
    bit fd, fr, cv;
    logic [TAG_W-1:0] ct;
    ment_t m;
    fd = !reset && !flush && disp_valid && (occ < DEPTH);
    fr = !reset && !flush && done && outstanding;
    cv = !reset && !flush && commit_valid;
    ct = commit_tag;
    if (fd) exp_q.push_back(pend);
    @(posedge clk);
    #1;
    if (reset || flush) begin
      exp_q.delete(); mq.delete(); occ = 0; outstanding = 1'b0;
    end else begin
      if (fr) begin
        void'(mq.pop_front()); occ--; outstanding = 1'b0;
      end
      if (cv) begin
        foreach (mq[k]) if (!mq[k].is_load && mq[k].tag == ct) mq[k].committed = 1'b1;
      end
      if (fd) begin
        m.tag = pend.tag; m.is_load = pend.is_load; m.committed = 1'b0;
        mq.push_back(m); occ++;
      end
    end
  endtask

  // Random bus traffic: tags 0..15 always carry their fixed value, tags 16..31 carry junk
  // (only already-ready sources use those), and bus 1 sometimes shadows bus 0 with junk.
  task automatic rand_bus();
    logic [TAG_W-1:0] t;
    for (int b = 0; b < CDB_N; b++) begin
      cdb_valid[b] = 1'($urandom_range(1));
      t = TAG_W'($urandom_range(31));
      cdb_tag[b*TAG_W +: TAG_W] = t;
      cdb_data[b*XLEN +: XLEN] = (t < 16) ? val_of[t[3:0]] : $urandom;
    end
    if (cdb_valid[0] && $urandom_range(3) == 0) begin
      cdb_valid[1] = 1'b1;
      cdb_tag[TAG_W +: TAG_W] = cdb_tag[0 +: TAG_W];
      cdb_data[XLEN +: XLEN] = ~cdb_data[0 +: XLEN];
    end
    commit_valid = ($urandom_range(4) < 2);
    if (mq.size() > 0) commit_tag = mq[$urandom_range(mq.size() - 1)].tag;
    else commit_tag = TAG_W'($urandom_range(31));
  endtask

  task automatic rand_disp();
    bit ld, r1, r2;
    logic [TAG_W-1:0] t1, t2;
    logic [XLEN-1:0] v1, v2;
    ld = 1'($urandom_range(1));
    r1 = 1'($urandom_range(1));
    r2 = ld ? 1'b1 : 1'($urandom_range(1));
    t1 = r1 ? TAG_W'(16 + $urandom_range(15)) : TAG_W'($urandom_range(15));
    t2 = r2 ? TAG_W'(16 + $urandom_range(15)) : TAG_W'($urandom_range(15));
    v1 = $urandom; v2 = $urandom;
    set_disp(ld, seq, CTRL_W'($urandom), r1, t1, v1, r2, t2, v2,
             r1 ? v1 : val_of[t1[3:0]], r2 ? v2 : val_of[t2[3:0]]);
    if (!flush && occ < DEPTH) seq++;
  endtask

  task automatic drain(bit rnd, int budget);
    int n;
    n = 0;
    disp_valid = 1'b0; issue_ready = 1'b1; done = 1'b1; flush = 1'b0;
    while (occ > 0 && n < budget) begin
      if (rnd) rand_bus();
      tick();
      n++;
    end
    chk("drain_empty", 96'(occ), 96'(0));
    idle();
  endtask

  // Monitor: occupancy vs model every cycle, idle payload, issue-once, and scoreboard pops.
  always @(negedge clk) begin : mon
    exp_t e;
    if (reset) begin
      prev_xfer = 1'b0;
    end else begin
      chk("count", 96'(count), 96'(occ));
      chk("empty", 96'(empty), 96'(occ == 0));
      chk("full", 96'(full), 96'(occ == DEPTH));
      chk("disp_ready", 96'(disp_ready), 96'(occ != DEPTH));
      if (!issue_valid)
        chk("idle_payload", 96'({issue_is_load, issue_tag, issue_ctrl, issue_base, issue_data}), 96'(0));
      if (prev_xfer) chk("issue_once", 96'(issue_valid), 96'(0));
      prev_xfer = 1'b0;
      if (issue_valid && issue_ready) begin
        prev_xfer = 1'b1;
        outstanding = 1'b1;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_issue: got tag %0h, expected no issue", issue_tag);
        end else begin
          e = exp_q.pop_front();
          chk("issue_tag", 96'(issue_tag), 96'(e.tag));
          chk("issue_is_load", 96'(issue_is_load), 96'(e.is_load));
          chk("issue_ctrl", 96'(issue_ctrl), 96'(e.ctrl));
          chk("issue_base", 96'(issue_base), 96'(e.base));
          chk("issue_data", 96'(issue_data), 96'(e.data));
          if (!e.is_load)
            chk("store_committed", 96'(mq.size() > 0 && mq[0].committed), 96'(1));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

  initial begin
    foreach (val_of[k]) val_of[k] = $urandom;
    idle();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    chk("rst_issue_valid", 96'(issue_valid), 96'(0));
    chk("rst_disp_ready", 96'(disp_ready), 96'(1));
    chk("rst_empty", 96'(empty), 96'(1));
    chk("rst_full", 96'(full), 96'(0));
    chk("rst_count", 96'(count), 96'(0));
    chk("rst_payload", 96'({issue_tag, issue_base, issue_data}), 96'(0));

    // Fill with eight ready loads while the LS unit stalls, then try a ninth.
    issue_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      set_disp(1'b1, TAG_W'(i), CTRL_W'(i), 1'b1, 5'd16, 32'h1000 + i, 1'b1, 5'd17, 32'h0, 32'h1000 + i, 32'h0);
      tick();
      if (i == 0) chk("first_issue_latency", 96'(issue_valid), 96'(1));
    end
    chk("fill_count", 96'(count), 96'(8));
    chk("fill_full", 96'(full), 96'(1));
    chk("fill_disp_ready", 96'(disp_ready), 96'(0));
    set_disp(1'b1, 5'd8, 8'h08, 1'b1, 5'd16, 32'h9999, 1'b1, 5'd17, 32'h0, 32'h9999, 32'h0);
    tick();
    idle();
    chk("ninth_count", 96'(count), 96'(8));
    chk("ninth_head_tag", 96'(issue_tag), 96'(0));
    chk("ninth_head_base", 96'(issue_base), 96'(32'h1000));
    drain(1'b0, 100);

    // Store with both operands ready waits for commit.
    set_disp(1'b0, 5'd3, 8'h33, 1'b1, 5'd16, 32'h55, 1'b1, 5'd17, 32'h66, 32'h55, 32'h66);
    tick();
    idle();
    issue_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("store_wait_commit", 96'(issue_valid), 96'(0));
    end
    commit_valid = 1'b1; commit_tag = 5'd3;
    tick();
    commit_valid = 1'b0;
    chk("store_after_commit", 96'(issue_valid), 96'(1));
    chk("store_base", 96'(issue_base), 96'(32'h55));
    chk("store_data", 96'(issue_data), 96'(32'h66));
    drain(1'b0, 20);

    // Both store sources woken in one cycle from different buses.
    issue_ready = 1'b0;
    set_disp(1'b0, 5'd10, 8'hA0, 1'b0, 5'd7, 32'hDEAD, 1'b0, 5'd9, 32'hBEEF, 32'h100, 32'hAB);
    tick();
    idle();
    cdb_valid = 2'b11; cdb_tag = {5'd9, 5'd7}; cdb_data = {32'hAB, 32'h100};
    tick();
    cdb_valid = '0;
    chk("mcdb_needs_commit", 96'(issue_valid), 96'(0));
    commit_valid = 1'b1; commit_tag = 5'd10;
    tick();
    commit_valid = 1'b0;
    chk("mcdb_valid", 96'(issue_valid), 96'(1));
    chk("mcdb_base", 96'(issue_base), 96'(32'h100));
    chk("mcdb_data", 96'(issue_data), 96'(32'hAB));
    drain(1'b0, 20);

    // Dispatch-time bypass from bus 1.
    issue_ready = 1'b0;
    set_disp(1'b1, 5'd11, 8'h11, 1'b0, 5'd4, 32'hBAD, 1'b1, 5'd17, 32'h0, 32'h2000, 32'h0);
    cdb_valid = 2'b10; cdb_tag = {5'd4, 5'd0}; cdb_data = {32'h2000, 32'h0};
    tick();
    idle();
    chk("bypass_valid", 96'(issue_valid), 96'(1));
    chk("bypass_base", 96'(issue_base), 96'(32'h2000));
    drain(1'b0, 20);

    // done against an unissued head must be ignored.
    issue_ready = 1'b1;
    set_disp(1'b0, 5'd12, 8'h12, 1'b1, 5'd16, 32'h77, 1'b1, 5'd17, 32'h88, 32'h77, 32'h88);
    tick();
    idle();
    done = 1'b1;
    tick(); tick();
    done = 1'b0;
    chk("done_unissued_count", 96'(count), 96'(1));
    commit_valid = 1'b1; commit_tag = 5'd12;
    tick();
    commit_valid = 1'b0;
    drain(1'b0, 20);

    // Twenty dispatch/retire pairs walk the pointers past the wrap.
    for (int i = 0; i < 20; i++) begin
      set_disp(1'b1, TAG_W'(13 + i), CTRL_W'(i), 1'b1, 5'd16, 32'h3000 + i, 1'b1, 5'd17, 32'h0, 32'h3000 + i, 32'h0);
      tick();
      drain(1'b0, 20);
    end

    // Flush with a dispatch in flight.
    issue_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      set_disp(1'b1, TAG_W'(i), 8'h0, 1'b1, 5'd16, 32'h10 + i, 1'b1, 5'd17, 32'h0, 32'h10 + i, 32'h0);
      tick();
    end
    set_disp(1'b1, 5'd4, 8'h0, 1'b1, 5'd16, 32'h14, 1'b1, 5'd17, 32'h0, 32'h14, 32'h0);
    flush = 1'b1;
    tick();
    idle();
    chk("flush_empty", 96'(empty), 96'(1));
    chk("flush_count", 96'(count), 96'(0));
    chk("flush_issue_valid", 96'(issue_valid), 96'(0));
    set_disp(1'b1, 5'd20, 8'h20, 1'b1, 5'd16, 32'h4444, 1'b1, 5'd17, 32'h0, 32'h4444, 32'h0);
    tick();
    idle();
    chk("post_flush_tag", 96'(issue_tag), 96'(20));
    chk("post_flush_base", 96'(issue_base), 96'(32'h4444));
    drain(1'b0, 20);

    // Randomized traffic with occasional flushes.
    seq = '0;
    for (int c = 0; c < 3000; c++) begin
      flush = ($urandom_range(63) == 0);
      issue_ready = !flush && ($urandom_range(3) != 0);
      done = !flush && ($urandom_range(2) != 0);
      if ($urandom_range(9) < 6) rand_disp();
      else disp_valid = 1'b0;
      rand_bus();
      tick();
    end
    flush = 1'b0;
    drain(1'b1, 2000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lsq_multi_cdb.md
# lsq_multi_cdb

Parametrised in-order load/store queue between dispatch and the load/store unit. Entries are allocated in program order, capture base/data operands from up to `CDB_N` broadcast buses, and issue strictly from the head. Loads issue once their base is ready. Stores issue only after their base and data are ready and the ROB has marked them committed. Adds over the single-CDB queue: a full/ready handshake, a latched commit flag, an issue handshake with an issue-once guard, dispatch-time CDB bypass, and occupancy outputs.

## Interface
- `DEPTH`, 8, number of entries; power of two, at least 2.
- `TAG_W`, 5, ROB tag width.
- `XLEN`, 32, operand width.
- `CTRL_W`, 8, opaque control payload width (func, size, sign), carried through unchanged.
- `CDB_N`, 2, number of forwarding buses.
- `clk` in 1: clock; every register updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `flush` in 1: synchronous; clears the queue the same way as reset.
- `disp_valid` in 1: dispatch request.
- `disp_ready` out 1: the queue accepts dispatch; equals `!full`.
- `disp_is_load` in 1: 1 = load, 0 = store.
- `disp_tag` in TAG_W: ROB tag of the instruction.
- `disp_ctrl` in CTRL_W: control payload.
- `disp_src1_ready`, `disp_src2_ready` in 1 each: operand already valid.
- `disp_src1_tag`, `disp_src2_tag` in TAG_W each: producer tags.
- `disp_src1_val`, `disp_src2_val` in XLEN each: operand values; src1 = base address, src2 = store data.
- `cdb_valid` in CDB_N: per-bus valid.
- `cdb_tag` in CDB_N*TAG_W: per-bus tag; bus i occupies bits [i*TAG_W +: TAG_W].
- `cdb_data` in CDB_N*XLEN: per-bus data; bus i occupies bits [i*XLEN +: XLEN].
- `commit_valid` in 1, `commit_tag` in TAG_W: ROB store-commit notification.
- `issue_valid` out 1, `issue_ready` in 1: issue handshake.
- `issue_is_load` out 1, `issue_tag` out TAG_W, `issue_ctrl` out CTRL_W: head instruction fields.
- `issue_base`, `issue_data` out XLEN each: head operand values.
- `done` in 1: the LS unit has finished the head instruction.
- `count` out $clog2(DEPTH)+1: occupancy.
- `empty` out 1, `full` out 1: occupancy flags.

## Operation
- Each entry holds: valid, is_load, committed, issued, tag, ctrl, and per source a ready bit, a tag and a value.
- Pointers `head` and `tail` are $clog2(DEPTH) bits wide and wrap modulo DEPTH.
- `count` increments on dispatch, decrements on retire, and is unchanged when both happen in the same cycle.
- **Dispatch.** Fires when `disp_valid && disp_ready`.
  - Writes the entry at `tail`, with committed = 0 and issued = 0, then increments `tail`.
  - Bypass: a source that arrives not ready captures its value and is stored as ready if its tag matches a valid CDB bus in the same cycle.
  - When `full`, dispatch is ignored. This holds even if a retire happens in the same cycle, because `full` is computed from the registered `count`.
- **Wakeup.** For every valid entry, each not-ready source compares its tag against all valid buses.
  - On a match the source captures the data and becomes ready.
  - If several buses match, the lowest bus index wins.
  - src1 and src2 may wake in the same cycle.
  - Sources that are already ready are never overwritten.
- **Commit.** When `commit_valid` is high, every valid store entry whose tag equals `commit_tag` sets committed = 1.
  - The flag stays set until the entry is freed.
  - Commit may arrive before, while, or after the store's operands become ready.
- **Issue.** All issue outputs are combinational from the registered head entry.
  - `issue_valid = head.valid && !head.issued && src1.ready && (is_load || (src2.ready && committed))`.
  - A transfer happens when `issue_valid && issue_ready`; it sets `head.issued` for the next cycle.
  - The `issue_*` payload outputs are driven to 0 whenever `issue_valid` = 0.
- **Retire.** `done` is honoured only when the registered `head.issued` = 1.
  - An honoured `done` clears `head.valid` and increments `head`.
  - Otherwise `done` is ignored.
- **Flush / reset.**
  - Priority: flush/reset over everything else in that cycle.
  - Clears all valid bits, sets head = tail = 0 and count = 0.
  - Dispatch, commit and CDB inputs in that same cycle are dropped.
  - Reset values: `issue_valid` 0, `disp_ready` 1, `empty` 1, `full` 0, `count` 0, all payload outputs 0.

## Timing
- Dispatch → entry visible: 1 cycle. A ready load dispatched at cycle N into an empty queue gives `issue_valid` = 1 at N+1.
- CDB or commit at cycle N → visible at the head's issue condition at N+1.
- Issue is zero-latency from state: `issue_valid` rises in the same cycle the head becomes eligible.
- Holding issue: `issue_valid` and the payload stay stable until `issue_ready`.
- After issue: `issue_valid` drops the cycle after the transfer and stays low until retire.
- Retire: a `done` at cycle N frees the entry at N+1; the next head can issue at N+1.
- Back-to-back throughput: one instruction per 2 cycles (issue, then `done` at the earliest the next cycle).

## Test plan
- **Reset and fill.** Reset, then dispatch 8 loads with base ready and `issue_ready` = 0 → `count` = 8, `full` = 1, `disp_ready` = 0; a 9th dispatch is dropped and `tail` does not move.
- **Store gated by commit.** Dispatch a store with tag 3 and both sources ready; hold commit for 5 cycles → `issue_valid` = 0 throughout. Pulse `commit_tag` = 3 → `issue_valid` = 1 on the next cycle, with the values unchanged.
- **Multi-CDB wakeup.** Store with src1 tag 7 and src2 tag 9, both not ready. In the same cycle drive `cdb[0]` = (7, 0x100) and `cdb[1]` = (9, 0xAB) → both sources ready next cycle; after commit, `issue_base` = 0x100 and `issue_data` = 0xAB.
- **Dispatch bypass.** Dispatch a load with src1 tag 4 not ready while `cdb[1]` = (4, 0x2000) in the same cycle → `issue_valid` = 1 at N+1 with `issue_base` = 0x2000.
- **Issue-once and retire.**
  - Issue a load with `issue_ready` = 1 → `issue_valid` = 0 the next cycle.
  - Pulse `done` → `count` decrements and the second entry issues.
  - `done` pulsed while the head is unissued → no effect.
- **Wrap and flush.**
  - Perform 20 dispatch/retire pairs with DEPTH = 8 → correct order of `issue_tag` across the pointer wrap.
  - Assert `flush` mid-sequence while `disp_valid` = 1 → next cycle `empty` = 1, `count` = 0, `issue_valid` = 0, and the flushed dispatch is not stored.
